spi_arb: RTL and testbench
==========================

# spi_arb

Round-robin arbiter and transfer sequencer that shares the single SPI master (`spi_top`) between `N_REQ` requesters. It sits between the requesters and the SPI master's register port (`Addr`/`Wr`/`DataWr`/`DataRd`). For each granted request it programs the slave select, TX byte and configuration, starts the transfer, polls for completion, reads back the RX byte, deselects the slave and returns the result to the requester.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters, 2..8.
- `TIMEOUT_CYC`, 16'd4096: poll limit in `Clk` cycles. Used only with `SPI_ARB_TIMEOUT_EN`.

Ports:
- Clocking: one clock; reset is asynchronous and active-high.
- `Clk`, input, 1: system clock.
- `Rst`, input, 1: asynchronous reset, active-high.
- `Req`, input, N_REQ: per-requester transfer request (level).
- `ReqData`, input, 8*N_REQ: TX byte; requester i uses `[8i+7:8i]`.
- `ReqSlave`, input, 3*N_REQ: slave index 0..7 per requester.
- `CPol`, input, 1: static SPI config.
- `CPha`, input, 1: static SPI config.
- `CPre`, input, 4: static SPI config.
- `Grant`, output, N_REQ: one-hot, held for the whole transaction.
- `Done`, output, N_REQ: one-hot, 1-cycle completion pulse.
- `RxByte`, output, 8: received byte, valid in the `Done` cycle.
- `Err`, output, 1: timeout flag, pulses with `Done`. Tied 0 without `SPI_ARB_TIMEOUT_EN`.
- `Busy`, output, 1: high in every state except IDLE.
- `RegAddr`, output, 2: drives SPI master `Addr`.
- `RegWr`, output, 1: drives SPI master `Wr`.
- `RegDataWr`, output, 8: drives SPI master `DataWr`.
- `RegDataRd`, input, 8: from SPI master `DataRd`. Combinational read: valid in the same cycle as `RegAddr`.

## Operation
SPI master register map:
- 0: CFG. Bit 0 `CPol`, bit 1 `CPha`, bits 5:2 `CPre`, bit 7 `StartTx` (write-1 starts).
- 1: STATUS. Bit 0 = `EndTx`.
- 2: write TX / read RX.
- 3: `SlaveSelectors`, active-low.

FSM states and actions (one cycle each unless noted):
- IDLE: if any `Req` is set, pick the winner round-robin, latch its data and slave index into local registers, assert its `Grant` bit, then go to SEL.
- SEL: write `~(8'h01 << slave)` to address 3.
- TX: write the latched byte to address 2.
- START: write `{1'b1, 1'b0, CPre, CPha, CPol}` to address 0.
- WAIT: single cycle. Masks a stale `EndTx` left from the previous transfer.
- POLL: drive address 0x1. Remain here while `RegDataRd[0]==0`; go to RD on 1.
- RD: drive address 2 and capture `RegDataRd` into `RxByte`.
- DESEL: write 8'hFF to address 3.
- DONE: pulse `Done[granted]`, then clear `Grant`, then return to IDLE.

Arbitration and request handling:
- Round-robin pointer = last granted index. The search starts at pointer+1 and wraps modulo N_REQ.
- `Req` withdrawn after grant: ignored. The transaction completes and `Done` still pulses.
- `Req` held through DONE: eligible again in IDLE, but ranked behind other pending requesters.
- `ReqData`/`ReqSlave` changes after grant: no effect, because both are latched in IDLE.

Output defaults:
- `RegWr` is 0 in all states except SEL, TX, START and DESEL.
- `RegAddr`/`RegDataWr` are 0 when not in use.

## Timing
- Reset values:
  - `Grant`=0, `Done`=0, `RxByte`=0, `Err`=0, `Busy`=0.
  - `RegAddr`=0, `RegWr`=0, `RegDataWr`=0.
  - State = IDLE, RR pointer = N_REQ-1, so requester 0 wins first.
- Latency:
  - `Req` sampled high in IDLE to `Grant` high: 1 cycle.
  - `Grant` to POLL entry: 4 cycles.
  - First POLL cycle seeing `EndTx`=1 to `Done`: 3 cycles (RD, DESEL, DONE).
  - Back-to-back transfers: IDLE costs 1 cycle between transactions.
- Reset asserted mid-transaction:
  - Return to IDLE immediately and drop `Grant`.
  - No `Done` is issued.
  - `RegWr` goes to 0 asynchronously.
- Simultaneous requests in IDLE: exactly one grant per arbitration.

## Configuration
- `SPI_ARB_TIMEOUT_EN` defined:
  - A 16-bit counter clears on WAIT and increments in POLL.
  - When it reaches `TIMEOUT_CYC`, go to DESEL, skipping RD.
  - DONE then pulses with `Err`=1 and `RxByte`=0.
- `SPI_ARB_TIMEOUT_EN` undefined: POLL waits indefinitely, no counter is built, and `Err` is constant 0.

## Structure
- Package `spi_arb_pkg` holds:
  - the state enum;
  - register address constants (CFG, STATUS, DATA, SS);
  - the CFG bit positions;
  - `SS_NONE` = 8'hFF.
- Sub-module `spi_arb_rr`:
  - Combinational round-robin picker.
  - Inputs: `Req` and the pointer. Outputs: one-hot winner and its index.
  - The pointer register stays in `spi_arb`.

## Test plan
- Single request: `Req[0]`, data 8'hA5, slave 2, `CPre`=3. Expected bus writes in order:
  - addr3 ← 8'hFB;
  - addr2 ← 8'hA5;
  - addr0 ← 8'h8C;
  - POLL until the bench model sets `EndTx`; RX 8'h3C;
  - then `Done[0]` with `RxByte`=8'h3C and addr3 ← 8'hFF.
- All four `Req` high continuously: the grant order is 0, 1, 2, 3, 0. Each `Done` arrives one-hot and never overlaps another `Grant`.
- Stale `EndTx`=1 held from the previous transfer through WAIT, then 0 for 10 cycles: POLL does not exit early, and `Done` comes 3 cycles after `EndTx` rises.
- `Req[1]` dropped and `ReqData` changed right after grant: the original byte is still written, and `Done[1]` still pulses.
- `Rst` asserted during POLL: all outputs are 0 in the same cycle. After release, a pending `Req[2]` is granted after `Req[0]` by RR order.
- With `SPI_ARB_TIMEOUT_EN` and `TIMEOUT_CYC`=20, `EndTx` stuck at 0: after 20 POLL cycles the sequence goes to DESEL (addr3 ← 8'hFF), then `Done` and `Err` pulse with `RxByte`=0.

Source files
------------

// File: rtl/spi_arb_pkg.sv
// Shared types and SPI master register map for the spi_arb transfer sequencer.
package spi_arb_pkg;

    typedef enum logic [3:0] {
        StIdle,
        StSel,
        StTx,
        StStart,
        StWait,
        StPoll,
        StRd,
        StDesel,
        StDone
    } state_e;

    localparam logic [1:0] ADDR_CFG    = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_DATA   = 2'd2;
    localparam logic [1:0] ADDR_SS     = 2'd3;

    localparam int unsigned CFG_CPOL     = 0;
    localparam int unsigned CFG_CPHA     = 1;
    localparam int unsigned CFG_CPRE_LSB = 2;
    localparam int unsigned CFG_START    = 7;

    localparam logic [7:0] SS_NONE = 8'hFF;

    function automatic logic [7:0] cfg_word(input logic cpol, input logic cpha,
                                            input logic [3:0] cpre);
        logic [7:0] w;
        w                        = '0;
        w[CFG_CPOL]              = cpol;
        w[CFG_CPHA]              = cpha;
        w[CFG_CPRE_LSB +: 4]     = cpre;
        w[CFG_START]             = 1'b1;
        return w;
    endfunction

    // Slave selects are active-low: only the addressed slave's bit is cleared.
    function automatic logic [7:0] ss_word(input logic [2:0] slave);
        return ~(8'h01 << slave);
    endfunction

endpackage

// File: rtl/spi_arb_rr.sv
// Combinational round-robin picker: search starts one past the pointer and wraps.
module spi_arb_rr
    import spi_arb_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] win_onehot,
    output logic [IDX_W-1:0] win_idx
);

    int unsigned cand;
    logic        found;

    always_comb begin
        win_onehot = '0;
        win_idx    = '0;
        cand       = 0;
        found      = 1'b0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            cand = (32'(ptr) + k) % N_REQ;
            if (!found && req[cand[IDX_W-1:0]]) begin
                win_onehot[cand[IDX_W-1:0]] = 1'b1;
                win_idx                     = cand[IDX_W-1:0];
                found                       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_arb.sv
// Round-robin arbiter sharing one SPI master between N_REQ requesters.
// Optional poll timeout enabled by defining SPI_ARB_TIMEOUT_EN.
module spi_arb
    import spi_arb_pkg::*;
#(
    parameter int unsigned N_REQ       = 4,
    parameter logic [15:0] TIMEOUT_CYC = 16'd4096
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic [N_REQ-1:0]   Req,
    input  logic [8*N_REQ-1:0] ReqData,
    input  logic [3*N_REQ-1:0] ReqSlave,
    input  logic               CPol,
    input  logic               CPha,
    input  logic [3:0]         CPre,
    output logic [N_REQ-1:0]   Grant,
    output logic [N_REQ-1:0]   Done,
    output logic [7:0]         RxByte,
    output logic               Err,
    output logic               Busy,
    output logic [1:0]         RegAddr,
    output logic               RegWr,
    output logic [7:0]         RegDataWr,
    input  logic [7:0]         RegDataRd
);

    localparam int unsigned IDX_W = $clog2(N_REQ);

    state_e             state_q, state_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [7:0]         data_q, data_d;
    logic [2:0]         slave_q, slave_d;
    logic [7:0]         rx_q, rx_d;
    logic [N_REQ-1:0]   win_onehot;
    logic [IDX_W-1:0]   win_idx;
    logic               timeout;

    spi_arb_rr #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr (
        .req        (Req),
        .ptr        (ptr_q),
        .win_onehot (win_onehot),
        .win_idx    (win_idx)
    );

`ifdef SPI_ARB_TIMEOUT_EN
    logic [15:0] cnt_q, cnt_d;
    logic        err_q, err_d;

    assign timeout = (state_q == StPoll) && ((cnt_q + 16'd1) == TIMEOUT_CYC);

    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        if (state_q == StIdle) err_d = 1'b0;
        if (state_q == StWait) begin
            cnt_d = '0;
        end else if (state_q == StPoll) begin
            cnt_d = cnt_q + 16'd1;
        end
        if (timeout && !RegDataRd[0]) err_d = 1'b1;
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign Err = (state_q == StDone) && err_q;
`else
    logic unused_timeout_cyc;

    assign unused_timeout_cyc = ^TIMEOUT_CYC;
    assign timeout            = 1'b0;
    assign Err                = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        data_d  = data_q;
        slave_d = slave_q;
        rx_d    = rx_q;
        unique case (state_q)
            StIdle: begin
                if (|Req) begin
                    grant_d = win_onehot;
                    ptr_d   = win_idx;
                    for (int unsigned i = 0; i < N_REQ; i++) begin
                        if (win_onehot[i]) begin
                            data_d  = ReqData[8*i +: 8];
                            slave_d = ReqSlave[3*i +: 3];
                        end
                    end
                    state_d = StSel;
                end
            end
            StSel:   state_d = StTx;
            StTx:    state_d = StStart;
            StStart: state_d = StWait;
            // One dead cycle so a stale EndTx from the last transfer is never polled.
            StWait:  state_d = StPoll;
            StPoll: begin
                if (RegDataRd[0]) begin
                    state_d = StRd;
                end else if (timeout) begin
                    rx_d    = '0;
                    state_d = StDesel;
                end
            end
            StRd: begin
                rx_d    = RegDataRd;
                state_d = StDesel;
            end
            StDesel: state_d = StDone;
            StDone: begin
                grant_d = '0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= StIdle;
            grant_q <= '0;
            ptr_q   <= IDX_W'(N_REQ - 1);
            data_q  <= '0;
            slave_q <= '0;
            rx_q    <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            data_q  <= data_d;
            slave_q <= slave_d;
            rx_q    <= rx_d;
        end
    end

    // Bus signals decode straight from state so reset clears them asynchronously.
    always_comb begin
        RegAddr   = 2'd0;
        RegWr     = 1'b0;
        RegDataWr = 8'h00;
        unique case (state_q)
            StSel: begin
                RegAddr   = ADDR_SS;
                RegWr     = 1'b1;
                RegDataWr = ss_word(slave_q);
            end
            StTx: begin
                RegAddr   = ADDR_DATA;
                RegWr     = 1'b1;
                RegDataWr = data_q;
            end
            StStart: begin
                RegAddr   = ADDR_CFG;
                RegWr     = 1'b1;
                RegDataWr = cfg_word(CPol, CPha, CPre);
            end
            StPoll:  RegAddr = ADDR_STATUS;
            StRd:    RegAddr = ADDR_DATA;
            StDesel: begin
                RegAddr   = ADDR_SS;
                RegWr     = 1'b1;
                RegDataWr = SS_NONE;
            end
            default: ;
        endcase
    end

    assign Grant  = grant_q;
    assign Done   = (state_q == StDone) ? grant_q : '0;
    assign RxByte = rx_q;
    assign Busy   = (state_q != StIdle);

endmodule

// File: tb/tb_spi_arb.sv
// Scoreboard bench for spi_arb with a behavioural SPI master register model.
// Covers the timeout path only when SPI_ARB_TIMEOUT_EN is defined.
module tb_spi_arb;

    localparam int unsigned N = 4;
`ifdef SPI_ARB_TIMEOUT_EN
    localparam logic [15:0] TO_CYC = 16'd20;
`else
    localparam logic [15:0] TO_CYC = 16'd4096;
`endif

    logic           Clk;
    logic           Rst;
    logic [N-1:0]   Req;
    logic [8*N-1:0] ReqData;
    logic [3*N-1:0] ReqSlave;
    logic           CPol, CPha;
    logic [3:0]     CPre;
    logic [N-1:0]   Grant, Done;
    logic [7:0]     RxByte;
    logic           Err, Busy;
    logic [1:0]     RegAddr;
    logic           RegWr;
    logic [7:0]     RegDataWr, RegDataRd;

    spi_arb #(
        .N_REQ       (N),
        .TIMEOUT_CYC (TO_CYC)
    ) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .Req       (Req),
        .ReqData   (ReqData),
        .ReqSlave  (ReqSlave),
        .CPol      (CPol),
        .CPha      (CPha),
        .CPre      (CPre),
        .Grant     (Grant),
        .Done      (Done),
        .RxByte    (RxByte),
        .Err       (Err),
        .Busy      (Busy),
        .RegAddr   (RegAddr),
        .RegWr     (RegWr),
        .RegDataWr (RegDataWr),
        .RegDataRd (RegDataRd)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // SPI master model: EndTx stays stale for one cycle after StartTx, then
    // reads 0 for lat cycles, then 1 until the next start.
    logic       endtx, arm;
    int         left, lat;
    logic [7:0] rx_val;

    assign RegDataRd = (RegAddr == 2'd1) ? {7'b0, endtx} :
                       (RegAddr == 2'd2) ? rx_val : 8'h00;

    always @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            arm   <= 1'b0;
            endtx <= 1'b0;
            left  <= 0;
        end else if (RegWr && RegAddr == 2'd0 && RegDataWr[7]) begin
            arm <= 1'b1;
        end else if (arm) begin
            arm   <= 1'b0;
            endtx <= 1'b0;
            left  <= lat;
        end else if (left > 0) begin
            left <= left - 1;
            if (left == 1) endtx <= 1'b1;
        end
    end

    typedef struct packed {
        logic [1:0] addr;
        logic [7:0] data;
    } wr_t;

    typedef struct packed {
        logic [N-1:0] done;
        logic [7:0]   rx;
        logic         err;
    } done_t;

    wr_t          exp_wr[$];
    done_t        exp_done[$];
    int           exp_grant[$];
    wr_t          cur_wr;
    done_t        cur_done;
    int           cur_grant;
    int           vectors = 0;
    int           miscompares = 0;
    int           grants_seen = 0;
    logic [N-1:0] prev_grant = '0;

    always @(negedge Clk) begin
        if (!Rst) begin
            if (RegWr) begin
                vectors++;
                assert (exp_wr.size() != 0) else begin
                    miscompares++;
                    $error("FAIL wr_unexpected: got addr %0d data %02h, expected no write",
                           RegAddr, RegDataWr);
                end
                if (exp_wr.size() != 0) begin
                    cur_wr = exp_wr.pop_front();
                    vectors++;
                    assert ({RegAddr, RegDataWr} === {cur_wr.addr, cur_wr.data}) else begin
                        miscompares++;
                        $error("FAIL bus_write: got addr %0d data %02h, expected addr %0d data %02h",
                               RegAddr, RegDataWr, cur_wr.addr, cur_wr.data);
                    end
                end
            end
            if (Done != '0) begin
                vectors++;
                assert (exp_done.size() != 0) else begin
                    miscompares++;
                    $error("FAIL done_unexpected: got Done %b, expected none", Done);
                end
                if (exp_done.size() != 0) begin
                    cur_done = exp_done.pop_front();
                    vectors++;
                    assert ({Done, RxByte, Err} === {cur_done.done, cur_done.rx, cur_done.err})
                    else begin
                        miscompares++;
                        $error("FAIL done_result: got Done %b Rx %02h Err %b, expected %b %02h %b",
                               Done, RxByte, Err, cur_done.done, cur_done.rx, cur_done.err);
                    end
                end
                vectors++;
                assert (Grant === Done) else begin
                    miscompares++;
                    $error("FAIL done_grant_overlap: got Grant %b, expected %b", Grant, Done);
                end
            end
            if (prev_grant == '0 && Grant != '0) begin
                grants_seen++;
                vectors++;
                assert (exp_grant.size() != 0) else begin
                    miscompares++;
                    $error("FAIL grant_unexpected: got Grant %b, expected none", Grant);
                end
                if (exp_grant.size() != 0) begin
                    cur_grant = exp_grant.pop_front();
                    vectors++;
                    assert (Grant === N'(1) << cur_grant) else begin
                        miscompares++;
                        $error("FAIL grant_order: got Grant %b, expected requester %0d",
                               Grant, cur_grant);
                    end
                end
            end
        end
        prev_grant <= Grant;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic push_xfer(input int idx, input logic [7:0] data, input logic [2:0] slave,
                             input logic [7:0] cfg, input logic [7:0] rx, input logic err,
                             input logic full);
        exp_grant.push_back(idx);
        exp_wr.push_back('{addr: 2'd3, data: ~(8'h01 << slave)});
        exp_wr.push_back('{addr: 2'd2, data: data});
        exp_wr.push_back('{addr: 2'd0, data: cfg});
        if (full) begin
            exp_wr.push_back('{addr: 2'd3, data: 8'hFF});
            exp_done.push_back('{done: N'(1) << idx, rx: rx, err: err});
        end
    endtask

    task automatic wait_grant(input int idx);
        int c;
        c = 0;
        while (Grant[idx] !== 1'b1 && c < 300) begin
            @(negedge Clk);
            c++;
        end
        vectors++;
        assert (Grant[idx] === 1'b1) else begin
            miscompares++;
            $error("FAIL grant_wait: got Grant %b, expected bit %0d within 300 cycles", Grant, idx);
        end
    endtask

    task automatic wait_drain();
        int c;
        c = 0;
        while ((exp_wr.size() != 0 || exp_done.size() != 0 || Busy) && c < 600) begin
            @(negedge Clk);
            c++;
        end
        vectors++;
        assert (exp_wr.size() == 0 && exp_done.size() == 0 && Busy === 1'b0) else begin
            miscompares++;
            $error("FAIL drain: got %0d writes %0d dones pending Busy %b, expected all 0",
                   exp_wr.size(), exp_done.size(), Busy);
        end
    endtask

    task automatic cycles_to_done(input int expected, input string tag);
        int c;
        c = 0;
        while (Done == '0 && c < 200) begin
            @(negedge Clk);
            c++;
        end
        vectors++;
        assert (c == expected) else begin
            miscompares++;
            $error("FAIL %s: got Done after %0d cycles, expected %0d", tag, c, expected);
        end
    endtask

    initial begin
        Rst      = 1'b1;
        Req      = '0;
        ReqData  = '0;
        ReqSlave = '0;
        CPol     = 1'b0;
        CPha     = 1'b0;
        CPre     = 4'd0;
        lat      = 1;
        rx_val   = 8'h00;

        tick(2);
        vectors++;
        assert ({Grant, Done, RxByte, Err, Busy, RegAddr, RegWr, RegDataWr} === '0) else begin
            miscompares++;
            $error("FAIL reset_state: got Grant %b Done %b Rx %02h Err %b Busy %b Addr %0d Wr %b Dw %02h, expected all 0",
                   Grant, Done, RxByte, Err, Busy, RegAddr, RegWr, RegDataWr);
        end
        Rst = 1'b0;
        tick(1);

        // All four requesting continuously: 0,1,2,3,0.
        CPol     = 1'b1;
        CPha     = 1'b1;
        CPre     = 4'd5;
        lat      = 2;
        rx_val   = 8'h5A;
        ReqData  = {8'h44, 8'h33, 8'h22, 8'h11};
        ReqSlave = {3'd3, 3'd2, 3'd1, 3'd0};
        push_xfer(0, 8'h11, 3'd0, 8'h97, 8'h5A, 1'b0, 1'b1);
        push_xfer(1, 8'h22, 3'd1, 8'h97, 8'h5A, 1'b0, 1'b1);
        push_xfer(2, 8'h33, 3'd2, 8'h97, 8'h5A, 1'b0, 1'b1);
        push_xfer(3, 8'h44, 3'd3, 8'h97, 8'h5A, 1'b0, 1'b1);
        push_xfer(0, 8'h11, 3'd0, 8'h97, 8'h5A, 1'b0, 1'b1);
        Req = 4'hF;
        for (int c = 0; c < 1000 && grants_seen < 5; c++) @(negedge Clk);
        Req = '0;
        wait_drain();

        // Single request with latency checks.
        CPol           = 1'b0;
        CPha           = 1'b0;
        CPre           = 4'd3;
        lat            = 3;
        rx_val         = 8'h3C;
        ReqData[7:0]   = 8'hA5;
        ReqSlave[2:0]  = 3'd2;
        push_xfer(0, 8'hA5, 3'd2, 8'h8C, 8'h3C, 1'b0, 1'b1);
        Req = 4'b0001;
        tick(1);
        vectors++;
        assert (Grant === 4'b0001) else begin
            miscompares++;
            $error("FAIL grant_latency: got Grant %b, expected 0001", Grant);
        end
        Req = '0;
        tick(4);
        vectors++;
        assert ({RegAddr, RegWr, Busy} === {2'd1, 1'b0, 1'b1}) else begin
            miscompares++;
            $error("FAIL poll_entry: got Addr %0d Wr %b Busy %b, expected 1 0 1",
                   RegAddr, RegWr, Busy);
        end
        wait_drain();

        // Stale EndTx held through WAIT, then 10 zero polls.
        lat             = 10;
        rx_val          = 8'h81;
        ReqData[31:24]  = 8'hC3;
        ReqSlave[11:9]  = 3'd7;
        push_xfer(3, 8'hC3, 3'd7, 8'h8C, 8'h81, 1'b0, 1'b1);
        Req = 4'b1000;
        tick(1);
        Req = '0;
        cycles_to_done(17, "stale_endtx");
        wait_drain();

        // Withdrawn request and changed data after grant.
        lat            = 2;
        rx_val         = 8'hE7;
        ReqData[15:8]  = 8'h6D;
        ReqSlave[5:3]  = 3'd5;
        push_xfer(1, 8'h6D, 3'd5, 8'h8C, 8'hE7, 1'b0, 1'b1);
        Req = 4'b0010;
        wait_grant(1);
        Req           = '0;
        ReqData[15:8] = 8'h77;
        ReqSlave[5:3] = 3'd1;
        wait_drain();

        // Reset during POLL, then RR order from a fresh pointer.
        lat            = 50;
        ReqData[7:0]   = 8'h0F;
        ReqSlave[2:0]  = 3'd0;
        ReqData[23:16] = 8'hD2;
        ReqSlave[8:6]  = 3'd4;
        push_xfer(0, 8'h0F, 3'd0, 8'h8C, 8'h00, 1'b0, 1'b0);
        Req = 4'b0001;
        wait_grant(0);
        tick(4);
        Req = 4'b0101;
        #2;
        Rst = 1'b1;
        #1;
        vectors++;
        assert ({Grant, Done, RxByte, Err, Busy, RegAddr, RegWr, RegDataWr} === '0) else begin
            miscompares++;
            $error("FAIL async_reset: got Grant %b Done %b Rx %02h Err %b Busy %b Addr %0d Wr %b Dw %02h, expected all 0",
                   Grant, Done, RxByte, Err, Busy, RegAddr, RegWr, RegDataWr);
        end
        lat    = 2;
        rx_val = 8'h42;
        push_xfer(0, 8'h0F, 3'd0, 8'h8C, 8'h42, 1'b0, 1'b1);
        push_xfer(2, 8'hD2, 3'd4, 8'h8C, 8'h42, 1'b0, 1'b1);
        tick(1);
        Rst = 1'b0;
        wait_grant(0);
        Req = 4'b0100;
        wait_grant(2);
        Req = '0;
        wait_drain();

`ifdef SPI_ARB_TIMEOUT_EN
        // EndTx stuck low: 20 polls, then DESEL and an error completion.
        lat            = 1000;
        rx_val         = 8'h99;
        ReqData[7:0]   = 8'h5C;
        ReqSlave[2:0]  = 3'd6;
        push_xfer(0, 8'h5C, 3'd6, 8'h8C, 8'h00, 1'b1, 1'b1);
        Req = 4'b0001;
        tick(1);
        Req = '0;
        cycles_to_done(25, "timeout_latency");
        wait_drain();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
